// File: rtl/wb_load_unit.sv
// Write-back / load unit in front of the register file.
// One instruction in flight. Non-loads write back one cycle after accept.
// Loads issue a word read, wait for the data, then align and extend it
// before the single write-back cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a new instruction
// S_REQ  | word read request held on mem_read_o until accepted
// S_WAIT | waiting for read data, mem_rdata_ready_o high
// S_WB   | register file write for one cycle (suppressed when rd == 0)
module wb_load_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [ADDR_WIDTH-1:0] in_rd_i,
   input  logic [DATA_WIDTH-1:0] in_result_i,
   input  logic                  in_is_load_i,
   input  logic [2:0]            in_load_type_i,
   input  logic [DATA_WIDTH-1:0] in_rt_data_i,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic                  mem_read_o,
   input  logic                  mem_req_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_rdata_valid_i,
   output logic                  mem_rdata_ready_o,
   output logic                  rf_wen_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WB   = 2'd3
   } state_t;

   localparam logic [2:0] LT_LB  = 3'b000;
   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LWL = 3'b010;
   localparam logic [2:0] LT_LBU = 3'b100;
   localparam logic [2:0] LT_LHU = 3'b101;
   localparam logic [2:0] LT_LWR = 3'b110;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            ltype_q, ltype_d;
   logic [DATA_WIDTH-1:0] rt_q, rt_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic [1:0]            off;
   logic [4:0]            sh_l;
   logic [4:0]            sh_r;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] aligned;

   // Byte-lane selection and LWL/LWR merge of the returned word with old rt.
   // LWL shifts the word up by (3-off) bytes keeping the low rt bytes;
   // LWR shifts it down by off bytes keeping the high rt bytes.
   always_comb begin
      off      = addr_q[1:0];
      sh_l     = {2'd3 - off, 3'b000};
      sh_r     = {off, 3'b000};
      byte_sel = mem_rdata_i[{off, 3'b000} +: 8];
      half_sel = mem_rdata_i[{off[1], 4'b0000} +: 16];
      case (ltype_q)
         LT_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU:  aligned = {24'h0, byte_sel};
         LT_LH:   aligned = {{16{half_sel[15]}}, half_sel};
         LT_LHU:  aligned = {16'h0, half_sel};
         LT_LWL:  aligned = (mem_rdata_i << sh_l) | (rt_q & ~(32'hFFFF_FFFF << sh_l));
         LT_LWR:  aligned = (mem_rdata_i >> sh_r) | (rt_q & ~(32'hFFFF_FFFF >> sh_r));
         default: aligned = mem_rdata_i;   // LW, and 111 behaves as LW
      endcase
   end

   // Next-state and capture of the accepted instruction / load result.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      ltype_d = ltype_q;
      rt_d    = rt_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               rd_d    = in_rd_i;
               addr_d  = in_result_i;
               ltype_d = in_load_type_i;
               rt_d    = in_rt_data_i;
               if (in_is_load_i) begin
                  state_d = S_REQ;
               end else begin
                  wdata_d = in_result_i;
                  state_d = S_WB;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rdata_valid_i) begin
               wdata_d = aligned;
               state_d = S_WB;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         rd_q    <= '0;
         addr_q  <= '0;
         ltype_q <= '0;
         rt_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         ltype_q <= ltype_d;
         rt_q    <= rt_d;
         wdata_q <= wdata_d;
      end
   end

   // Handshake and write-port outputs decoded from registered state only.
   always_comb begin
      in_ready_o        = (state_q == S_IDLE);
      mem_read_o        = (state_q == S_REQ);
      mem_rdata_ready_o = (state_q == S_WAIT);
      rf_wen_o          = (state_q == S_WB) && (rd_q != '0);
      mem_addr_o        = {addr_q[DATA_WIDTH-1:2], 2'b00};
      rf_waddr_o        = rd_q;
      rf_wdata_o        = wdata_q;
   end

endmodule
